// File: rtl/sad_trigger_ctrl_pkg.sv
// sad_trig_pkg: shared state encoding, default widths and helpers for the SAD trigger qualifier
package sad_trig_pkg;
    typedef enum logic [2:0] {IDLE, WAIT, FIRE, HOLD, DONE} sad_trig_state_t;
    localparam int DEF_COUNT_WIDTH   = 8;
    localparam int DEF_HOLDOFF_WIDTH = 16;
    localparam int DEF_PULSE_WIDTH   = 4;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/sad_trigger_ctrl_if.sv
// sad_trigger_ctrl_if: signal bundle between the SAD comparator side and the trigger qualifier
//   master: drives armed_and_ready, match, multiple_triggers, holdoff, pulse_len; reads trigger and status
//   slave:  the qualifier; reads the controls, drives trigger, triggered, num_triggers, num_missed
interface sad_trigger_ctrl_if #(
    parameter int pCOUNT_WIDTH   = sad_trig_pkg::DEF_COUNT_WIDTH,
    parameter int pHOLDOFF_WIDTH = sad_trig_pkg::DEF_HOLDOFF_WIDTH,
    parameter int pPULSE_WIDTH   = sad_trig_pkg::DEF_PULSE_WIDTH
);
    logic                      armed_and_ready;
    logic                      match;
    logic                      multiple_triggers;
    logic [pHOLDOFF_WIDTH-1:0] holdoff;
    logic [pPULSE_WIDTH-1:0]   pulse_len;
    logic                      trigger;
    logic                      triggered;
    logic [pCOUNT_WIDTH-1:0]   num_triggers;
    logic [pCOUNT_WIDTH-1:0]   num_missed;
    modport master (
        output armed_and_ready, match, multiple_triggers, holdoff, pulse_len,
        input  trigger, triggered, num_triggers, num_missed
    );
    modport slave (
        input  armed_and_ready, match, multiple_triggers, holdoff, pulse_len,
        output trigger, triggered, num_triggers, num_missed
    );
endinterface

// File: rtl/sad_trigger_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
//   clk, rst (sync, active-high), clear (sync zero), inc (count up one), value (current count, stops at all-ones)
module sat_counter #(
    parameter int pWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [pWIDTH-1:0] value
);
    logic [pWIDTH-1:0] value_q, value_d;

    always_comb value_d = clear ? '0 : (inc && value_q != '1) ? value_q + pWIDTH'(1) : value_q;

    always_ff @(posedge clk) value_q <= rst ? '0 : value_d;

    assign value = value_q;
endmodule

// File: rtl/sad_trigger_ctrl.sv
// sad_trigger_ctrl: qualifies raw SAD matches into a stretched, holdoff-spaced scope trigger with status
//   clk_adc: sole clock; reset: sync active-high
//   bus (slave): armed_and_ready, match, multiple_triggers, holdoff, pulse_len in;
//                trigger, triggered, num_triggers, num_missed out
module sad_trigger_ctrl
    import sad_trig_pkg::*;
#(
    parameter int pCOUNT_WIDTH   = DEF_COUNT_WIDTH,
    parameter int pHOLDOFF_WIDTH = DEF_HOLDOFF_WIDTH,
    parameter int pPULSE_WIDTH   = DEF_PULSE_WIDTH
) (
    input  logic             clk_adc,
    input  logic             reset,
    sad_trigger_ctrl_if.slave bus
);
    localparam int SW = max_int(pHOLDOFF_WIDTH, pPULSE_WIDTH);

    sad_trig_state_t         state_q, state_d;
    logic [pPULSE_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [SW-1:0]           space_cnt_q, space_cnt_d;
    logic                    triggered_q, triggered_d;
    logic                    accept, miss, arm;
    logic [SW-1:0]           p_len, h_len, s_len;
    logic [pPULSE_WIDTH-1:0] p_load;

    // P = max(pulse_len,1), S = max(P,holdoff); both latched only on acceptance
    always_comb begin
        p_len  = bus.pulse_len == '0 ? SW'(1) : SW'(bus.pulse_len);
        h_len  = SW'(bus.holdoff);
        s_len  = p_len > h_len ? p_len : h_len;
        p_load = bus.pulse_len == '0 ? '0 : bus.pulse_len - pPULSE_WIDTH'(1);
    end

    // Spacing counter runs S-1 down to 0 from the cycle after acceptance, so it reads 0
    // exactly S cycles after the accepted match; it never drops below the pulse counter.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        space_cnt_d = space_cnt_q == '0 ? '0 : space_cnt_q - SW'(1);
        accept      = 1'b0;
        miss        = 1'b0;
        arm         = 1'b0;
        if (!bus.armed_and_ready) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    arm     = 1'b1;
                end
                WAIT: accept = bus.match;
                FIRE, HOLD: begin
                    if (state_q == FIRE && pulse_cnt_q != '0) begin
                        pulse_cnt_d = pulse_cnt_q - pPULSE_WIDTH'(1);
                        miss        = bus.match;
                    end else if (space_cnt_q != '0) begin
                        state_d = HOLD;
                        miss    = bus.match;
                    end else begin
                        // last cycle of the spacing window: a match here retriggers without a gap
                        accept  = bus.match && bus.multiple_triggers;
                        miss    = bus.match && !bus.multiple_triggers;
                        state_d = bus.multiple_triggers ? WAIT : DONE;
                    end
                end
                DONE: miss = bus.match;
                default: state_d = IDLE;
            endcase
        end
        if (accept) begin
            state_d     = FIRE;
            pulse_cnt_d = p_load;
            space_cnt_d = s_len - SW'(1);
        end
        triggered_d = arm ? 1'b0 : accept ? 1'b1 : triggered_q;
    end

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            state_q     <= IDLE;
            pulse_cnt_q <= '0;
            space_cnt_q <= '0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            space_cnt_q <= space_cnt_d;
            triggered_q <= triggered_d;
        end
    end

    assign bus.trigger   = state_q == FIRE;
    assign bus.triggered = triggered_q;

    sat_counter #(.pWIDTH(pCOUNT_WIDTH)) u_num_triggers (
        .clk   (clk_adc),
        .rst   (reset),
        .clear (arm),
        .inc   (accept),
        .value (bus.num_triggers)
    );

    sat_counter #(.pWIDTH(pCOUNT_WIDTH)) u_num_missed (
        .clk   (clk_adc),
        .rst   (reset),
        .clear (arm),
        .inc   (miss),
        .value (bus.num_missed)
    );
endmodule

// File: tb/tb_sad_trigger_ctrl.sv
// tb_sad_trigger_ctrl: directed and randomized checks of sad_trigger_ctrl against an acceptance-time model
module tb_sad_trigger_ctrl;
    logic clk_adc = 1'b0;
    logic reset;

    sad_trigger_ctrl_if bus ();

    sad_trigger_ctrl dut (
        .clk_adc (clk_adc),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_adc = ~clk_adc;

    localparam int CMAX = 255;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // Model: remembers when the last match was accepted and with which S, and through
    // which edge the trigger must stay high; everything else follows from those.
    int edge_n     = 0;
    bit in_session = 0;
    bit has_acc    = 0;
    int last_acc   = 0;
    int last_s     = 0;
    int trig_last  = -1;
    bit m_trig_st  = 0;
    int m_ntrig    = 0;
    int m_nmiss    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int p, s;
        edge_n++;
        p = bus.pulse_len == 0 ? 1 : int'(bus.pulse_len);
        s = p > int'(bus.holdoff) ? p : int'(bus.holdoff);
        if (reset) begin
            in_session = 0; has_acc = 0; trig_last = -1;
            m_trig_st = 0; m_ntrig = 0; m_nmiss = 0;
        end else if (!bus.armed_and_ready) begin
            in_session = 0; trig_last = -1;
        end else if (!in_session) begin
            in_session = 1; has_acc = 0;
            m_trig_st = 0; m_ntrig = 0; m_nmiss = 0;
        end else if (bus.match) begin
            if (bus.multiple_triggers ? (!has_acc || edge_n >= last_acc + last_s) : !has_acc) begin
                has_acc = 1; last_acc = edge_n; last_s = s;
                trig_last = edge_n + p - 1;
                m_trig_st = 1;
                m_ntrig = m_ntrig < CMAX ? m_ntrig + 1 : CMAX;
            end else begin
                m_nmiss = m_nmiss < CMAX ? m_nmiss + 1 : CMAX;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_adc);
        model_edge();
        @(negedge clk_adc);
        check("trigger", 32'(bus.trigger), 32'(edge_n <= trig_last));
        check("triggered", 32'(bus.triggered), 32'(m_trig_st));
        check("num_triggers", 32'(bus.num_triggers), 32'(m_ntrig));
        check("num_missed", 32'(bus.num_missed), 32'(m_nmiss));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises, high;
        logic prev;
        reset = 1'b1;
        bus.armed_and_ready = 1'b0;
        bus.match = 1'b0;
        bus.multiple_triggers = 1'b0;
        bus.holdoff = '0;
        bus.pulse_len = 4'd1;
        tick();
        tick();
        check("reset_trigger", 32'(bus.trigger), 0);
        check("reset_ntrig", 32'(bus.num_triggers), 0);
        reset = 1'b0;
        tick();

        // single mode, P=1, H=0: matches at A+5 and A+20
        bus.armed_and_ready = 1'b1;
        tick();
        repeat (4) tick();
        bus.match = 1'b1; tick(); bus.match = 1'b0;
        check("t1_rise", 32'(bus.trigger), 1);
        tick();
        check("t1_width", 32'(bus.trigger), 0);
        repeat (13) tick();
        bus.match = 1'b1; tick(); bus.match = 1'b0;
        check("t1_triggered", 32'(bus.triggered), 1);
        check("t1_ntrig", 32'(bus.num_triggers), 1);
        check("t1_nmiss", 32'(bus.num_missed), 1);

        // multiple mode, P=4, H=10: continuous match for 30 cycles from A+3
        bus.armed_and_ready = 1'b0; tick();
        bus.multiple_triggers = 1'b1; bus.pulse_len = 4'd4; bus.holdoff = 16'd10;
        bus.armed_and_ready = 1'b1; tick();
        repeat (2) tick();
        bus.match = 1'b1;
        rises = 0; high = 0; prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.trigger) begin
                high++;
                if (!prev) begin
                    check("t2_rise_at", 32'(i), 32'(10 * rises));
                    rises++;
                end
            end
            prev = bus.trigger;
        end
        bus.match = 1'b0;
        check("t2_rises", 32'(rises), 3);
        check("t2_high", 32'(high), 12);
        check("t2_ntrig", 32'(bus.num_triggers), 3);
        check("t2_nmiss", 32'(bus.num_missed), 27);

        // multiple mode, pulse_len 0 (as 1), H=0: 5 back-to-back matches
        bus.armed_and_ready = 1'b0; tick();
        bus.pulse_len = 4'd0; bus.holdoff = 16'd0;
        bus.armed_and_ready = 1'b1; tick();
        tick();
        bus.match = 1'b1;
        high = 0;
        repeat (5) begin
            tick();
            high += int'(bus.trigger);
        end
        bus.match = 1'b0;
        tick();
        check("t3_high", 32'(high), 5);
        check("t3_after", 32'(bus.trigger), 0);
        check("t3_ntrig", 32'(bus.num_triggers), 5);

        // disarm mid-pulse, P=8, then re-arm
        bus.armed_and_ready = 1'b0; tick();
        bus.multiple_triggers = 1'b0; bus.pulse_len = 4'd8;
        bus.armed_and_ready = 1'b1; tick();
        tick();
        bus.match = 1'b1; tick(); bus.match = 1'b0;
        high = int'(bus.trigger);
        repeat (2) begin
            tick();
            high += int'(bus.trigger);
        end
        bus.armed_and_ready = 1'b0;
        tick();
        high += int'(bus.trigger);
        check("t4_width", 32'(high), 3);
        repeat (2) tick();
        check("t4_keep_ntrig", 32'(bus.num_triggers), 1);
        check("t4_keep_triggered", 32'(bus.triggered), 1);
        bus.armed_and_ready = 1'b1; tick();
        check("t4_clear_ntrig", 32'(bus.num_triggers), 0);
        check("t4_clear_triggered", 32'(bus.triggered), 0);
        bus.match = 1'b1; tick(); bus.match = 1'b0;
        check("t4_rearm_rise", 32'(bus.trigger), 1);

        // saturation: 300 back-to-back accepted matches
        bus.armed_and_ready = 1'b0; tick();
        bus.multiple_triggers = 1'b1; bus.pulse_len = 4'd1; bus.holdoff = 16'd0;
        bus.armed_and_ready = 1'b1; tick();
        bus.match = 1'b1;
        repeat (300) tick();
        check("t5_sat", 32'(bus.num_triggers), 255);
        repeat (20) tick();
        check("t5_sat_hold", 32'(bus.num_triggers), 255);
        bus.match = 1'b0;

        // reset while in HOLD
        bus.armed_and_ready = 1'b0; tick();
        bus.pulse_len = 4'd2; bus.holdoff = 16'd20;
        bus.armed_and_ready = 1'b1; tick();
        tick();
        bus.match = 1'b1; tick(); bus.match = 1'b0;
        repeat (4) tick();
        reset = 1'b1; tick();
        check("t6_trigger", 32'(bus.trigger), 0);
        check("t6_triggered", 32'(bus.triggered), 0);
        check("t6_ntrig", 32'(bus.num_triggers), 0);
        check("t6_nmiss", 32'(bus.num_missed), 0);
        reset = 1'b0; bus.armed_and_ready = 1'b0; bus.match = 1'b1;
        repeat (3) tick();
        check("t6_ignored", 32'(bus.num_triggers), 0);
        bus.armed_and_ready = 1'b1; tick();
        check("t6_arm_cycle", 32'(bus.trigger), 0);
        tick();
        check("t6_first", 32'(bus.trigger), 1);
        bus.match = 1'b0;

        // randomized traffic; mode only changes while disarmed
        repeat (3000) begin
            if (!bus.armed_and_ready) begin
                bus.multiple_triggers = 1'($urandom_range(1));
                bus.armed_and_ready = $urandom_range(3) != 0;
            end else begin
                bus.armed_and_ready = $urandom_range(99) >= 2;
            end
            reset = $urandom_range(499) == 0;
            bus.match = $urandom_range(99) < 35;
            if ($urandom_range(19) == 0) begin
                bus.holdoff = 16'($urandom_range(12));
                bus.pulse_len = 4'($urandom_range(5));
            end
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
